multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
Multi-cycle instruction sequencer for the 16-bit RISC core. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with instruction and data memory. Emits per-state control pulses (pc_en, jmp, mem_wr, reg_wr, sel) to the PC, register file, ALU mux and data memory. Sits between the instruction register and the datapath; owns all instruction timing.

Parameters:
DIV_CYCLES, 8, number of cycles EXEC is held for DIV (opcode 0000); legal range 1..255.
TIMEOUT_CYCLES, 16, max cycles waited for imem_ack/dmem_ack before bus error; legal range 2..255.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
run  input  1  1 = allow next instruction fetch; 0 = park in IDLE after current instruction
opcode_in  input  4  opcode field from instruction memory data, valid when imem_ack=1
imem_ack  input  1  instruction memory read done
dmem_ack  input  1  data memory access done
imem_req  output  1  instruction fetch request
dmem_req  output  1  data memory request
ir_load  output  1  load instruction register
pc_en  output  1  advance PC (1-cycle pulse)
jmp  output  1  PC takes jump target (1-cycle pulse, with pc_en)
mem_wr  output  1  data memory write strobe
reg_wr  output  1  register file write (1-cycle pulse)
sel  output  2  writeback mux: 00 MOV, 01 memory, 10 ALU
busy  output  1  1 in any state except IDLE and HALT
bus_err  output  1  sticky memory timeout flag
instr_count  output  16  retired instruction count (see Optional Feature)

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. rst sampled at posedge clk; dominates everything; takes effect mid-instruction (any state, any pending handshake is dropped).
- Reset values: state=IDLE, all outputs 0, opcode register 0, counters 0, bus_err 0, instr_count 0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs decoded from state + latched opcode + wait counter only; no combinational input-to-output path.
- IDLE: run=1 -> FETCH, else stay.
- FETCH: imem_req=1. On imem_ack: latch opcode_in, ir_load=1 that cycle, -> DECODE. Wait counter increments each non-ack cycle; ack in the cycle counter reaches TIMEOUT_CYCLES-1 still wins; otherwise at that count -> HALT, bus_err<=1.
- DECODE: 1 cycle, -> EXEC. sel driven from DECODE through WB: 0000-1011 -> 10; 1100 -> 00; 1101 -> 01; 1110/1111 -> 00; 00 in IDLE/FETCH/HALT.
- EXEC: ALU ops 0001-1011 and MOV 1100: 1 cycle -> WB. DIV 0000: held exactly DIV_CYCLES cycles (counter), then -> WB. READ 1101/WRT 1110: 1 cycle -> MEM. JUMP 1111: pc_en=1, jmp=1 this cycle, then -> FETCH if run=1 else IDLE.
- MEM: dmem_req=1; mem_wr=1 for WRT only, held with dmem_req. On dmem_ack -> WB. Timeout identical to FETCH.
- WB: pc_en=1; reg_wr=1 for all opcodes except WRT and JUMP. -> FETCH if run=1 else IDLE.
- Steady-state latency with immediate acks: ALU/MOV 4 cycles, READ/WRT 5, JUMP 3, DIV 3+DIV_CYCLES.
- run=0 mid-instruction: current instruction completes; stop only at WB/JUMP exit.
- HALT: all strobes 0, busy=0, bus_err=1; exit only by rst.
- Wait counter cleared on every state entry.

Optional Feature:
Macro INSTR_COUNT_EN. Defined: instr_count increments by 1 on every cycle pc_en=1 (one per retired instruction), wraps 0xFFFF -> 0x0000, reset to 0. Not defined: counter logic absent, instr_count tied to 16'h0000; port list unchanged.

Test Plan:
- rst=1 2 cycles then run=1, imem_ack=1, opcode_in=0001 -> imem_req cycle 1, DECODE, EXEC, WB with reg_wr=1, pc_en=1, sel=10; next imem_req at cycle 5.
- opcode 1110 with dmem_ack delayed 3 cycles -> dmem_req and mem_wr high 4 cycles, then WB: pc_en=1, reg_wr=0, sel=00.
- opcode 1111 -> in EXEC pc_en=1 and jmp=1 same cycle, no reg_wr, imem_req next cycle; opcode 0000 with DIV_CYCLES=8 -> EXEC lasts 8 cycles, reg_wr at WB.
- imem_ack held 0 with TIMEOUT_CYCLES=16 -> after 16 FETCH cycles HALT, bus_err=1, busy=0; ack arriving later ignored; rst clears bus_err.
- rst asserted during MEM of READ -> next cycle IDLE, dmem_req=0, all outputs 0; run=0 during EXEC of ADD -> WB completes, then IDLE, imem_req stays 0.
- INSTR_COUNT_EN defined, instr_count preloaded near wrap by running 65535 MOVs -> reads 0xFFFF then 0x0000 after next WB; macro undefined -> instr_count constant 0.

Source files
------------

// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: handshake, memory and control bus of the instruction sequencer
interface multicycle_sequencer_if;
    logic        run;
    logic [3:0]  opcode_in;
    logic        imem_ack;
    logic        dmem_ack;
    logic        imem_req;
    logic        dmem_req;
    logic        ir_load;
    logic        pc_en;
    logic        jmp;
    logic        mem_wr;
    logic        reg_wr;
    logic [1:0]  sel;
    logic        busy;
    logic        bus_err;
    logic [15:0] instr_count;
    modport slave (
        input  run, opcode_in, imem_ack, dmem_ack,
        output imem_req, dmem_req, ir_load, pc_en, jmp, mem_wr, reg_wr, sel, busy, bus_err, instr_count
    );
    modport master (
        output run, opcode_in, imem_ack, dmem_ack,
        input  imem_req, dmem_req, ir_load, pc_en, jmp, mem_wr, reg_wr, sel, busy, bus_err, instr_count
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB sequencer; INSTR_COUNT_EN enables the retired-instruction counter
module multicycle_sequencer #(
    parameter int DIV_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic                   clk,
    input logic                   rst,
    multicycle_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t     r_state, w_next;
    logic [3:0] r_op;
    logic [7:0] r_cnt;
    logic       r_bus_err;
    logic       w_to, w_div_done, w_mem_op, w_jump, w_wrt, w_dp;
    logic [1:0] w_sel;

    assign w_to       = r_cnt == 8'(TIMEOUT_CYCLES - 1);
    assign w_div_done = r_cnt == 8'(DIV_CYCLES - 1);
    assign w_jump     = r_op == 4'b1111;
    assign w_wrt      = r_op == 4'b1110;
    assign w_mem_op   = r_op == 4'b1101 || w_wrt;
    assign w_dp       = r_state == DECODE || r_state == EXEC || r_state == MEM || r_state == WB;
    assign w_sel      = r_op <= 4'b1011 ? 2'b10 : r_op == 4'b1101 ? 2'b01 : 2'b00;

    // next-state selection; a missing ack at the last allowed count parks in HALT
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.run ? FETCH : IDLE;
            FETCH:   w_next = bus.imem_ack ? DECODE : w_to ? HALT : FETCH;
            DECODE:  w_next = EXEC;
            EXEC:    w_next = r_op == 4'b0000 ? (w_div_done ? WB : EXEC)
                            : w_jump ? (bus.run ? FETCH : IDLE)
                            : w_mem_op ? MEM : WB;
            MEM:     w_next = bus.dmem_ack ? WB : w_to ? HALT : MEM;
            WB:      w_next = bus.run ? FETCH : IDLE;
            HALT:    w_next = HALT;
            default: w_next = IDLE;
        endcase
    end

    // state, latched opcode, wait counter (cleared on every state entry) and sticky bus error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_op      <= 4'b0000;
            r_cnt     <= 8'd0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_op      <= (r_state == FETCH && bus.imem_ack) ? bus.opcode_in : r_op;
            r_cnt     <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
            r_bus_err <= r_bus_err || w_next == HALT;
        end
    end

    // ir_load must coincide with the ack because that is the only cycle the fetched word is valid
    assign bus.imem_req = r_state == FETCH;
    assign bus.ir_load  = r_state == FETCH && bus.imem_ack;
    assign bus.dmem_req = r_state == MEM;
    assign bus.mem_wr   = r_state == MEM && w_wrt;
    assign bus.jmp      = r_state == EXEC && w_jump;
    assign bus.pc_en    = r_state == WB || bus.jmp;
    assign bus.reg_wr   = r_state == WB && !w_wrt && !w_jump;
    assign bus.sel      = w_dp ? w_sel : 2'b00;
    assign bus.busy     = r_state != IDLE && r_state != HALT;
    assign bus.bus_err  = r_bus_err;

`ifdef INSTR_COUNT_EN
    logic [15:0] r_instr_count;

    // one count per retired instruction, wrapping naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst) r_instr_count <= 16'h0000;
        else if (bus.pc_en) r_instr_count <= r_instr_count + 16'h0001;
    end

    assign bus.instr_count = r_instr_count;
`else
    assign bus.instr_count = 16'h0000;
`endif
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: randomized instruction stream checked cycle by cycle against a phase-list model
module tb_multicycle_sequencer;
    localparam int DIV = 8;
    localparam int TO  = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    int   ecnt  = 0;

    multicycle_sequencer_if bus();

    multicycle_sequencer #(.DIV_CYCLES(DIV), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // {imem_req, dmem_req, ir_load, pc_en, jmp, mem_wr, reg_wr, sel[1:0], busy, bus_err}
    function automatic logic [10:0] mk(input bit im, dm, il, pe, jp, mw, rw, input logic [1:0] s, input bit bu, be);
        return {im, dm, il, pe, jp, mw, rw, s, bu, be};
    endfunction

    // one clock cycle: inputs already driven, outputs compared mid-cycle, then advance past the edge
    task automatic step(input string tag, input logic [10:0] e);
        logic [10:0] o;
        @(negedge clk);
        o = {bus.imem_req, bus.dmem_req, bus.ir_load, bus.pc_en, bus.jmp, bus.mem_wr, bus.reg_wr,
             bus.sel, bus.busy, bus.bus_err};
        check(tag, {21'd0, o}, {21'd0, e});
`ifdef INSTR_COUNT_EN
        check({tag, "_cnt"}, {16'd0, bus.instr_count}, {16'd0, 16'(ecnt)});
`else
        check({tag, "_cnt"}, {16'd0, bus.instr_count}, 32'd0);
`endif
        if (e[7]) ecnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.run = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        ecnt = 0;
        step("reset", 11'd0);
        rst = 1'b0;
    endtask

    task automatic go();
        bus.run = 1'b1;
        step("idle_go", 11'd0);
    endtask

    // HALT is sticky: acks are ignored until reset, which clears bus_err
    task automatic halt_check();
        bus.imem_ack = 1'b1;
        bus.dmem_ack = 1'b1;
        bus.run = 1'b1;
        repeat (3) step("halt", mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1));
        do_reset();
    endtask

    // expected phases of one instruction from the FETCH cycle to its exit; df/dm are ack delays
    task automatic do_instr(input logic [3:0] op, input int df, input int dm, input bit rn, input bit rmem);
        logic [1:0] s;
        bit wrt;
        s = op <= 4'd11 ? 2'b10 : op == 4'd13 ? 2'b01 : 2'b00;
        wrt = op == 4'd14;
        for (int i = 0; i < df && i < TO; i++) begin
            bus.imem_ack = 1'b0;
            bus.run = 1'($urandom);
            step("fetch", mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
        end
        if (df >= TO) begin
            halt_check();
            return;
        end
        bus.imem_ack = 1'b1;
        bus.opcode_in = op;
        step("fetch_ack", mk(1, 0, 1, 0, 0, 0, 0, 2'b00, 1, 0));
        bus.imem_ack = 1'b0;
        bus.opcode_in = 4'($urandom);
        bus.run = 1'($urandom);
        step("decode", mk(0, 0, 0, 0, 0, 0, 0, s, 1, 0));
        if (op == 4'd15) begin
            bus.run = rn;
            step("jump", mk(0, 0, 0, 1, 1, 0, 0, s, 1, 0));
            return;
        end
        for (int i = 0; i < (op == 4'd0 ? DIV : 1); i++) begin
            bus.run = 1'($urandom);
            step("exec", mk(0, 0, 0, 0, 0, 0, 0, s, 1, 0));
        end
        if (op == 4'd13 || wrt) begin
            if (rmem) begin
                rst = 1'b1;
                step("mem_rst", mk(0, 1, 0, 0, 0, wrt, 0, s, 1, 0));
                rst = 1'b0;
                bus.run = 1'b0;
                ecnt = 0;
                step("post_rst", 11'd0);
                step("post_rst_idle", 11'd0);
                return;
            end
            for (int i = 0; i < dm && i < TO; i++) begin
                bus.dmem_ack = 1'b0;
                bus.run = 1'($urandom);
                step("mem", mk(0, 1, 0, 0, 0, wrt, 0, s, 1, 0));
            end
            if (dm >= TO) begin
                halt_check();
                return;
            end
            bus.dmem_ack = 1'b1;
            step("mem_ack", mk(0, 1, 0, 0, 0, wrt, 0, s, 1, 0));
            bus.dmem_ack = 1'b0;
        end
        bus.run = rn;
        step("wb", mk(0, 0, 0, 1, 0, 0, !wrt, s, 1, 0));
    endtask

    function automatic int rdelay();
        return ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 3));
    endfunction

    initial begin
        bit rn;
        bus.opcode_in = 4'd0;
        do_reset();
        step("reset_hold", 11'd0);
        go();
        do_instr(4'd1, 0, 0, 1, 0);
        do_instr(4'd14, 0, 3, 1, 0);
        do_instr(4'd15, 0, 0, 1, 0);
        do_instr(4'd0, 0, 0, 1, 0);
        do_instr(4'd12, TO - 1, 0, 1, 0);
        do_instr(4'd13, 2, TO - 1, 1, 0);
        do_instr(4'd2, 0, 0, 0, 0);
        step("idle_parked", 11'd0);
        go();
        do_instr(4'd3, 0, 0, 1, 0);
        do_instr(4'd5, TO, 0, 1, 0);
        go();
        do_instr(4'd14, 1, TO, 1, 0);
        go();
        do_instr(4'd13, 0, 0, 1, 1);
        go();
        for (int n = 0; n < 150; n++) begin
            rn = ($urandom_range(0, 3) != 0);
            do_instr(4'($urandom_range(0, 15)), rdelay(), rdelay(), rn, 0);
            if (!rn) begin
                bus.run = 1'b0;
                repeat ($urandom_range(0, 2)) step("idle_wait", 11'd0);
                go();
            end
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
